// File: rtl/spi_accel_responder_if.sv
// SPI pin bundle between an accelerometer controller (master) and the
// responder model (slave). Mode 3: SPI_CLK idles high.
interface spi_accel_responder_if;
    logic SPI_CLK;
    logic SPI_CSN;
    logic SPI_SDI;
    logic SPI_SDO;

    modport master (output SPI_CLK, output SPI_CSN, output SPI_SDI, input SPI_SDO);
    modport slave  (input SPI_CLK, input SPI_CSN, input SPI_SDI, output SPI_SDO);
endinterface

// File: rtl/spi_accel_responder.sv
// ADXL345-style SPI target model: oversampled mode-3 decoder, 64-byte register map,
// coherent X/Y/Z sample registers and INT1/INT2. Define SPI_RESP_MB_EN for burst access.
module spi_accel_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    spi_accel_responder_if.slave    spi,
    input  logic                    sample_valid,
    input  logic [15:0]             sample_x,
    input  logic [15:0]             sample_y,
    input  logic [15:0]             sample_z,
    input  logic                    activity_evt,
    output logic                    reg_write,
    output logic [5:0]              reg_wr_addr,
    output logic [7:0]              reg_wr_data,
    output logic [1:0]              interrupt
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdi_sync;
    logic sclk_q, csn_q;
    logic sclk_s, csn_s, sdi_s;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;

    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [5:0]  addr_q;
    logic        rw_q;
    logic        sdo_q;
    logic        burst_ok;

    logic        cmd_done, byte_done, load_read, write_commit;
    logic [7:0]  rx_byte;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;

    logic [7:0]  cfg_regs [6'h1D:6'h31];
    logic        data_ready, activity;
    logic [7:0]  int_source;
    logic [15:0] data_x, data_y, data_z;
    logic [15:0] pend_x, pend_y, pend_z;
    logic        pend_valid;

    function automatic logic is_writable(input logic [5:0] a);
        return ((a >= 6'h1D) && (a <= 6'h2F)) || (a == 6'h31);
    endfunction

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign csn_rise  = csn_s & ~csn_q;
    assign csn_fall  = ~csn_s & csn_q;
    assign int_source = {data_ready, 2'b00, activity, 4'b0000};
    assign spi.SPI_SDO = sdo_q;

`ifdef SPI_RESP_MB_EN
    logic mb_q;
    assign burst_ok = mb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mb_q <= 1'b0;
        else if (cmd_done)
            mb_q <= rx_byte[6];
    end
`else
    assign burst_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A detected CSN rise aborts from any state, so a partial byte never commits.
    always_comb begin
        state_next   = state;
        cmd_done     = 1'b0;
        byte_done    = 1'b0;
        rx_byte      = {rx_shift, sdi_s};
        if (csn_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (csn_fall) state_next = CMD;
                CMD: if (sclk_rise && bit_cnt == 3'd7) begin
                    cmd_done   = 1'b1;
                    state_next = DATA;
                end
                DATA: if (sclk_rise && bit_cnt == 3'd7) begin
                    byte_done  = 1'b1;
                    state_next = burst_ok ? DATA : DONE;
                end
                default: state_next = state;
            endcase
        end
        rd_addr      = cmd_done ? rx_byte[5:0] : addr_q + 6'd1;
        load_read    = (cmd_done && rx_byte[7]) || (byte_done && rw_q && burst_ok);
        write_commit = byte_done && !rw_q && is_writable(addr_q);
    end

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            6'h00: rd_data = DEVID;
            6'h30: rd_data = int_source;
            6'h32: rd_data = data_x[7:0];
            6'h33: rd_data = data_x[15:8];
            6'h34: rd_data = data_y[7:0];
            6'h35: rd_data = data_y[15:8];
            6'h36: rd_data = data_z[7:0];
            6'h37: rd_data = data_z[15:8];
            default: rd_data = is_writable(rd_addr) ? cfg_regs[rd_addr] : 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '1;
            csn_sync  <= '1;
            sdi_sync  <= '0;
            sclk_q    <= 1'b1;
            csn_q     <= 1'b1;
            bit_cnt   <= 3'd0;
            rx_shift  <= 7'd0;
            tx_shift  <= 8'd0;
            addr_q    <= 6'd0;
            rw_q      <= 1'b0;
            sdo_q     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SPI_CLK};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi.SPI_CSN};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi.SPI_SDI};
            sclk_q    <= sclk_s;
            csn_q     <= csn_s;

            if (state == IDLE)
                bit_cnt <= 3'd0;
            else if (sclk_rise && (state == CMD || state == DATA)) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte[6:0];
            end

            if (cmd_done) begin
                addr_q <= rx_byte[5:0];
                rw_q   <= rx_byte[7];
            end else if (byte_done && burst_ok)
                addr_q <= addr_q + 6'd1;

            if (load_read)
                tx_shift <= rd_data;
            else if (sclk_fall && state == DATA && rw_q)
                tx_shift <= {tx_shift[6:0], 1'b0};

            // SDO only carries data while a read byte is in flight.
            if (state == DATA && state_next == DATA && rw_q) begin
                if (sclk_fall)
                    sdo_q <= tx_shift[7];
            end else
                sdo_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write   <= 1'b0;
            reg_wr_addr <= 6'd0;
            reg_wr_data <= 8'd0;
            for (int i = 29; i <= 49; i++)
                cfg_regs[6'(i)] <= (i == 44) ? 8'h0A : 8'h00;
        end else begin
            reg_write <= write_commit;
            if (write_commit) begin
                reg_wr_addr      <= addr_q;
                reg_wr_data      <= rx_byte;
                cfg_regs[addr_q] <= rx_byte;
            end
        end
    end

    // Samples arriving mid-frame wait in a one-deep buffer so a burst read stays coherent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_x     <= 16'd0;
            data_y     <= 16'd0;
            data_z     <= 16'd0;
            pend_x     <= 16'd0;
            pend_y     <= 16'd0;
            pend_z     <= 16'd0;
            pend_valid <= 1'b0;
            data_ready <= 1'b0;
            activity   <= 1'b0;
            interrupt  <= 2'b00;
        end else begin
            if (csn_rise) begin
                pend_valid <= 1'b0;
                if (sample_valid) begin
                    data_x <= sample_x;
                    data_y <= sample_y;
                    data_z <= sample_z;
                end else if (pend_valid) begin
                    data_x <= pend_x;
                    data_y <= pend_y;
                    data_z <= pend_z;
                end
            end else if (sample_valid) begin
                if (state != IDLE) begin
                    pend_x     <= sample_x;
                    pend_y     <= sample_y;
                    pend_z     <= sample_z;
                    pend_valid <= 1'b1;
                end else begin
                    data_x <= sample_x;
                    data_y <= sample_y;
                    data_z <= sample_z;
                end
            end

            if (sample_valid)
                data_ready <= 1'b1;
            else if (load_read && rd_addr == 6'h30)
                data_ready <= 1'b0;

            if (activity_evt)
                activity <= 1'b1;
            else if (load_read && rd_addr == 6'h30)
                activity <= 1'b0;

            interrupt <= {|(int_source & cfg_regs[6'h2E] & cfg_regs[6'h2F]),
                          |(int_source & cfg_regs[6'h2E] & ~cfg_regs[6'h2F])};
        end
    end

endmodule

// File: doc/spi_accel_responder.md
# spi_accel_responder

SPI target-side model of the ADXL345-style accelerometer that the accelerometer SPI controller talks to. Decodes 16-bit (or longer, multi-byte) mode-3 SPI frames, serves a 64-byte register map with live X/Y/Z sample data, accepts configuration writes, and raises the two interrupt lines. It is used as a synthesizable stand-in for the sensor, either in the board-level testbench or on a second FPGA. All logic runs on one system clock that oversamples the SPI pins.

## Interface
- DEVID, 8'hE5: value returned at address 0x00.
- SYNC_STAGES, 2: flops in each SPI input synchronizer, minimum 2.
- clk  input  1  system clock, at least 8x SPI_CLK frequency.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- SPI_CLK  input  1  serial clock from the controller, CPOL=1/CPHA=1.
- SPI_CSN  input  1  chip select, active low.
- SPI_SDI  input  1  controller-to-target data, MSB first.
- SPI_SDO  output  1  target-to-controller data.
- sample_valid  input  1  one-cycle strobe: new sample on sample_x/y/z.
- sample_x, sample_y, sample_z  input  16 each  signed sample words.
- activity_evt  input  1  one-cycle strobe: sets INT_SOURCE[4].
- reg_write  output  1  one-cycle pulse per accepted write.
- reg_wr_addr  output  6  address of the accepted write.
- reg_wr_data  output  8  data of the accepted write.
- interrupt  output  2  [0]=INT1, [1]=INT2, registered, active high.

## Operation
- Frame: command byte {RW, MB, A[5:0]} then data byte(s). RW=1 is read.
- Inputs pass through SYNC_STAGES flops. SDI is sampled on the detected SCLK rise. SDO changes on the detected SCLK fall.
- State machine:
  - IDLE: CSN high. Goes to CMD on the detected CSN fall, which clears the bit counter.
  - CMD: shifts 8 bits. After the 8th rise it latches the address. For a read it also loads the shift register with reg[addr]. Next state is DATA.
  - DATA: shifts 8 bits.
    - Read: SDO presents bit 7 on the first fall after CMD.
    - Write: after the 8th rise, the byte is committed if the address is writable.
    - Then: next byte with addr+1 (wraps 0x3F to 0x00) if MB=1 and SPI_RESP_MB_EN is defined, else go to DONE.
  - DONE: ignores SCLK and holds SDO at 0.
  - Any state: a detected CSN rise returns to IDLE. A partial byte is discarded with no write.
- Register map:
  - 0x00: DEVID.
  - 0x1D–0x2F and 0x31: read/write config. BW_RATE (0x2C) resets to 0x0A, all others to 0x00.
  - 0x30 INT_SOURCE: read-only.
    - Bit 7 DATA_READY is set by sample_valid. Bit 4 ACTIVITY is set by activity_evt.
    - Cleared in the cycle its value is loaded for a read. A set in that same cycle wins.
  - 0x32–0x37: X/Y/Z low/high bytes, read-only.
  - All other addresses: read 0x00, writes ignored with no reg_write.
- Sample coherency:
  - sample_valid while CSN high updates the data registers immediately.
  - sample_valid while CSN low is held in a one-deep pending buffer, and a newer sample overwrites it.
  - The pending sample is applied on the CSN rise.
  - DATA_READY is set at the strobe, not at the deferred apply.
- interrupt[0] = |(INT_SOURCE & INT_ENABLE & ~INT_MAP). interrupt[1] = |(INT_SOURCE & INT_ENABLE & INT_MAP). Both are registered one cycle.

## Timing
- Reset values: SPI_SDO=0, reg_write=0, reg_wr_addr=0, reg_wr_data=0, interrupt=2'b00, state IDLE, data registers 0, INT_SOURCE 0. Reset mid-frame is asynchronous abort with no write.
- Edge detection latency is SYNC_STAGES+1 clk from the pin.
- SDO is valid SYNC_STAGES+2 clk after the pin-level SCLK fall. It must settle before the next rise, hence the 8x minimum clock ratio.
- reg_write asserts 1 clk after the detected 8th data rise, together with reg_wr_addr/reg_wr_data. Config registers update in that same cycle.
- SDO is 0 in IDLE, CMD, DONE and during write data.

## Configuration
- SPI_RESP_MB_EN defined: the MB bit enables burst with auto-increment across any number of bytes until CSN rises.
- SPI_RESP_MB_EN undefined: the MB bit is ignored. After one data byte the block enters DONE.

## Test plan
- Read 0x00 (command 0x80): SDO byte = 0xE5. No reg_write.
- Write 0x2D←0x08: reg_write pulses once with addr 0x2D, data 0x08. A subsequent read of 0x2D returns 0x08.
- sample_x=0x01F4 strobed with CSN high: read 0x32 gives 0xF4, read 0x33 gives 0x01. INT_SOURCE read gives 0x80, then a second read gives 0x00.
- Pending sample: sample_valid with x=0x1234 mid-frame while reading 0x32 (old 0xF4). Returns 0xF4; after the CSN rise, a read of 0x32 returns 0x34.
- INT_ENABLE=0x10 and INT_MAP=0x10, then activity_evt: interrupt=2'b10. Read 0x30 gives 0x10, then interrupt=2'b00.
- CSN rises after 4 data bits of a write to 0x24: no reg_write and 0x24 is unchanged. Burst read 0xF2 (MB=1) over 4 bytes gives X_LB, X_HB, Y_LB, Y_HB with the macro defined, and only X_LB then zeros without it.
